// File: rtl/locking_key_loader_if.sv
// locking_key_loader_if
//   Bundles the serial key-provisioning stream and the committed-key outputs
//   of locking_key_loader.
//   master : provisioning side (drives key_start / key_bit_valid / key_bit)
//   slave  : the loader (drives key_bit_ready / locking_key / key_valid /
//            key_busy / key_error)
interface locking_key_loader_if #(
  parameter int KEY_WIDTH = 255
);
  logic                 key_start;
  logic                 key_bit_valid;
  logic                 key_bit;
  logic                 key_bit_ready;
  logic [KEY_WIDTH-1:0] locking_key;
  logic                 key_valid;
  logic                 key_busy;
  logic                 key_error;

  modport master (
    output key_start, key_bit_valid, key_bit,
    input  key_bit_ready, locking_key, key_valid, key_busy, key_error
  );

  modport slave (
    input  key_start, key_bit_valid, key_bit,
    output key_bit_ready, locking_key, key_valid, key_busy, key_error
  );
endinterface

// File: rtl/locking_key_loader.sv
// locking_key_loader
//   Receives a locking key as a valid/ready serial bit stream, assembles it in
//   a shadow register and commits it to a stable parallel output only once all
//   KEY_WIDTH bits have arrived. locking_key is therefore either 0 or a
//   complete key, never a partial one.
//
//   Ports:
//     clk  - system clock, all state on the rising edge
//     rst  - synchronous active-high reset, highest priority
//     bus  - locking_key_loader_if.slave:
//              key_start      in  : pulse, starts/restarts a load
//              key_bit_valid  in  : key_bit carries a valid bit
//              key_bit        in  : serial data, first bit -> locking_key[0]
//              key_bit_ready  out : loader accepts a bit this cycle
//              locking_key    out : committed key
//              key_valid      out : locking_key holds a committed key
//              key_busy       out : load in progress
//              key_error      out : integrity failure (CRC build only)
//
//   Optional feature macro: KEY_LOADER_CRC_EN
//     When defined, a CRC-8 (poly 0x07, init 0) is computed over the key bits
//     and compared against 8 trailing CRC bits (MSB first) before committing.
module locking_key_loader #(
  parameter int KEY_WIDTH = 255,
  parameter int CNT_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  locking_key_loader_if.slave bus
);

`ifdef KEY_LOADER_CRC_EN
  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, DONE, ERROR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [KEY_WIDTH-1:0] shadow_reg;
  logic [KEY_WIDTH-1:0] key_reg;
  logic                 valid_reg;
  logic                 busy_reg;
  logic                 ready_reg;

  // Ready is itself registered, so the handshake only looks at flops plus the
  // incoming valid.
  logic                 xfer;
  logic [KEY_WIDTH-1:0] shadow_next;
  logic                 last_key_bit;

  assign xfer         = bus.key_bit_valid && ready_reg;
  assign shadow_next  = {bus.key_bit, shadow_reg[KEY_WIDTH-1:1]};
  assign last_key_bit = (count_reg == CNT_WIDTH'(KEY_WIDTH - 1));

`ifdef KEY_LOADER_CRC_EN
  logic [7:0] crc_reg;
  logic [7:0] rx_crc_reg;
  logic       error_reg;
  logic [7:0] crc_next;
  logic [7:0] rx_crc_next;

  assign crc_next    = {crc_reg[6:0], 1'b0} ^ ((crc_reg[7] ^ bus.key_bit) ? 8'h07 : 8'h00);
  assign rx_crc_next = {rx_crc_reg[6:0], bus.key_bit};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      shadow_reg <= '0;
      key_reg    <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      ready_reg  <= 1'b0;
`ifdef KEY_LOADER_CRC_EN
      crc_reg    <= '0;
      rx_crc_reg <= '0;
      error_reg  <= 1'b0;
`endif
    end else if (bus.key_start) begin
      // Restart from any state; a bit offered in this same cycle is dropped.
      state_reg  <= SHIFT;
      count_reg  <= '0;
      shadow_reg <= '0;
      key_reg    <= '0;
      valid_reg  <= 1'b0;
      busy_reg   <= 1'b1;
      ready_reg  <= 1'b1;
`ifdef KEY_LOADER_CRC_EN
      crc_reg    <= '0;
      rx_crc_reg <= '0;
      error_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        SHIFT: begin
          if (xfer) begin
            shadow_reg <= shadow_next;
            count_reg  <= count_reg + 1'b1;
`ifdef KEY_LOADER_CRC_EN
            crc_reg    <= crc_next;
            if (last_key_bit) begin
              // Count restarts to index the 8 trailing CRC bits.
              state_reg <= CHECK;
              count_reg <= '0;
            end
`else
            if (last_key_bit) begin
              // Commit uses shadow_next so the final bit lands in the same edge.
              state_reg <= DONE;
              key_reg   <= shadow_next;
              valid_reg <= 1'b1;
              busy_reg  <= 1'b0;
              ready_reg <= 1'b0;
            end
`endif
          end
        end
`ifdef KEY_LOADER_CRC_EN
        CHECK: begin
          if (xfer) begin
            rx_crc_reg <= rx_crc_next;
            count_reg  <= count_reg + 1'b1;
            if (count_reg == CNT_WIDTH'(7)) begin
              busy_reg  <= 1'b0;
              ready_reg <= 1'b0;
              if (rx_crc_next == crc_reg) begin
                state_reg <= DONE;
                key_reg   <= shadow_reg;
                valid_reg <= 1'b1;
              end else begin
                state_reg <= ERROR;
                error_reg <= 1'b1;
              end
            end
          end
        end
`endif
        default: begin
          // IDLE, DONE and ERROR hold until key_start or rst.
        end
      endcase
    end
  end

  assign bus.key_bit_ready = ready_reg;
  assign bus.locking_key   = key_reg;
  assign bus.key_valid     = valid_reg;
  assign bus.key_busy      = busy_reg;
`ifdef KEY_LOADER_CRC_EN
  assign bus.key_error     = error_reg;
`else
  assign bus.key_error     = 1'b0;
`endif

endmodule

// File: tb/tb_locking_key_loader.sv
module tb_locking_key_loader;
  localparam int KW = 255;
`ifdef KEY_LOADER_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif
  localparam int NBITS = KW + CRC_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  locking_key_loader_if #(.KEY_WIDTH(KW)) bus ();

  locking_key_loader #(.KEY_WIDTH(KW), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic [KW-1:0] key;
    bit            bubbles;
    bit            corrupt;
    logic [KW-1:0] exp_key;
    bit            exp_valid;
    bit            exp_error;
    int            exp_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [KW-1:0] key);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < KW; i++) begin
      fb = c[7] ^ key[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic start();
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
  endtask

  // Streams the key (plus CRC in the CRC build); counts cycles and how many
  // offered bits saw ready high.
  task automatic stream(input logic [KW-1:0] key, input bit bubbles, input bit corrupt,
                        output int cycles, output int rdy_cnt);
    logic [7:0] c;
    logic       b;
    c = crc8(key) ^ (corrupt ? 8'h01 : 8'h00);
    cycles  = 0;
    rdy_cnt = 0;
    for (int i = 0; i < NBITS; i++) begin
      b = (i < KW) ? key[i] : c[7 - (i - KW)];
      bus.key_bit_valid = 1'b1;
      bus.key_bit       = b;
      if (bus.key_bit_ready) rdy_cnt++;
      if (i == KW / 2) begin
        check("partial_key_hidden", bus.locking_key, '0);
        check("partial_valid_low", KW'(bus.key_valid), '0);
        check("partial_busy_high", KW'(bus.key_busy), KW'(1));
      end
      tick();
      cycles++;
      bus.key_bit_valid = 1'b0;
      bus.key_bit       = ~b;
      if (bubbles && i != NBITS - 1) begin
        tick();
        cycles++;
      end
    end
    bus.key_bit = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_key"},   bus.locking_key, '0);
    check({tag, "_valid"}, KW'(bus.key_valid), '0);
    check({tag, "_busy"},  KW'(bus.key_busy), '0);
    check({tag, "_ready"}, KW'(bus.key_bit_ready), '0);
    check({tag, "_error"}, KW'(bus.key_error), '0);
  endtask

  initial begin
    vec_t          v;
    int            cyc;
    int            rdy;
    logic [KW-1:0] k101;
    logic [KW-1:0] kedge;
    logic [KW-1:0] kmix;

    bus.key_start     = 1'b0;
    bus.key_bit_valid = 1'b0;
    bus.key_bit       = 1'b0;

    k101  = KW'(9'h101);
    kedge = (KW'(1) << (KW - 1)) | KW'(1);
    kmix  = {{(KW - 64){1'b0}}, 64'hDEAD_BEEF_0123_4567};

    vecs.push_back('{"continuous_101", k101,  1'b0, 1'b0, k101,  1'b1, 1'b0, NBITS});
    vecs.push_back('{"bubbles_101",    k101,  1'b1, 1'b0, k101,  1'b1, 1'b0, 2 * NBITS - 1});
    vecs.push_back('{"edge_bits",      kedge, 1'b0, 1'b0, kedge, 1'b1, 1'b0, NBITS});
    vecs.push_back('{"mixed_pattern",  kmix,  1'b1, 1'b0, kmix,  1'b1, 1'b0, 2 * NBITS - 1});
`ifdef KEY_LOADER_CRC_EN
    vecs.push_back('{"crc_corrupt",    k101,  1'b0, 1'b1, '0,    1'b0, 1'b1, NBITS});
`endif

    // Reset held two cycles, then released.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset");
    $display("reset: outputs after release checked");

    // Bits offered while idle are ignored.
    bus.key_bit_valid = 1'b1;
    bus.key_bit       = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.key_bit_valid = 1'b0;
    check_idle_outputs("idle_ignore");
    $display("idle: offered bits ignored");

    // Table-driven loads.
    foreach (vecs[i]) begin
      v = vecs[i];
      start();
      check({v.name, "_start_busy"},  KW'(bus.key_busy), KW'(1));
      check({v.name, "_start_ready"}, KW'(bus.key_bit_ready), KW'(1));
      stream(v.key, v.bubbles, v.corrupt, cyc, rdy);
      check({v.name, "_key"},    bus.locking_key, v.exp_key);
      check({v.name, "_valid"},  KW'(bus.key_valid), KW'(v.exp_valid));
      check({v.name, "_error"},  KW'(bus.key_error), KW'(v.exp_error));
      check({v.name, "_busy"},   KW'(bus.key_busy), '0);
      check({v.name, "_ready"},  KW'(bus.key_bit_ready), '0);
      check({v.name, "_cycles"}, KW'(cyc), KW'(v.exp_cycles));
      check({v.name, "_rdy_cnt"}, KW'(rdy), KW'(NBITS));
      $display("load %s: cycles=%0d valid=%0b error=%0b key=%h", v.name, cyc, bus.key_valid, bus.key_error, bus.locking_key);
    end

    // Error exits via key_start; also a plain check after any completed load.
    start();
    check("restart_error_clear", KW'(bus.key_error), '0);
    check("restart_valid_clear", KW'(bus.key_valid), '0);
    check("restart_key_clear",   bus.locking_key, '0);
    $display("restart: error/valid/key cleared by key_start");

    // DONE holds the key even with traffic on the bit interface.
    stream(k101, 1'b0, 1'b0, cyc, rdy);
    bus.key_bit_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.key_bit = i[0];
      tick();
    end
    bus.key_bit_valid = 1'b0;
    check("done_hold_key",   bus.locking_key, k101);
    check("done_hold_valid", KW'(bus.key_valid), KW'(1));
    $display("done: key held under idle traffic");

    // Abort/restart with a colliding bit on the restart cycle.
    start();
    bus.key_bit_valid = 1'b1;
    bus.key_bit       = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    bus.key_start = 1'b1;
    tick();
    bus.key_start     = 1'b0;
    bus.key_bit_valid = 1'b0;
    check("abort_valid_low", KW'(bus.key_valid), '0);
    stream(KW'(1), 1'b0, 1'b0, cyc, rdy);
    check("abort_key",   bus.locking_key, KW'(1));
    check("abort_valid", KW'(bus.key_valid), KW'(1));
    $display("abort: key=%h", bus.locking_key);

    // Reset in the middle of a load.
    start();
    bus.key_bit_valid = 1'b1;
    bus.key_bit       = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("midload_reset");
    for (int i = 0; i < 5; i++) tick();
    bus.key_bit_valid = 1'b0;
    check_idle_outputs("post_reset_ignore");
    start();
    stream(k101, 1'b0, 1'b0, cyc, rdy);
    check("post_reset_reload", bus.locking_key, k101);
    $display("midload reset: outputs cleared, reload key=%h", bus.locking_key);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/locking_key_loader.md
Name: locking_key_loader

Overview:
- Upstream stage for the locked datapath blocks, e.g. the obfuscated ALU with its 255-bit locking_key input.
- Receives the locking key serially from the key-provisioning interface over a valid/ready bit stream.
- Assembles the bits in a shadow register and commits the full key to a stable parallel output that feeds the locking_key ports.
- Exposes key_valid so downstream logic knows when the key is committed.

Parameters:
- KEY_WIDTH, 255, number of key bits; also the width of locking_key.
- CNT_WIDTH, 8, bit-counter width; must satisfy 2^CNT_WIDTH > KEY_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_start  input  1  single-cycle pulse; begins or restarts a key load.
- key_bit_valid  input  1  key_bit holds a valid serial bit.
- key_bit  input  1  serial key data, first bit received = locking_key[0].
- key_bit_ready  output  1  loader accepts a bit this cycle.
- locking_key  output  KEY_WIDTH  committed key to the locked datapath.
- key_valid  output  1  locking_key holds a fully committed key.
- key_busy  output  1  load in progress.
- key_error  output  1  integrity failure; only driven by the optional feature, else constant 0.

Behaviour:
- Reset, synchronous and active-high, takes priority over everything:
  - state=IDLE, count=0, shadow=0, locking_key=0.
  - key_valid=0, key_busy=0, key_bit_ready=0, key_error=0.
  - Reset mid-load discards all partial bits.
- States: IDLE, SHIFT, CHECK (feature only), DONE, ERROR (feature only).
- key_bit_ready=1 only in SHIFT and CHECK; key_busy=1 in the same states.
- Transfer occurs when key_bit_valid && key_bit_ready. key_bit_valid outside SHIFT/CHECK is ignored.
- IDLE: wait for key_start.
- key_start in any state:
  - next state SHIFT; count=0, shadow=0.
  - locking_key cleared to 0, key_valid=0, key_error=0.
  - key_start wins over a same-cycle transfer; that bit is discarded.
- SHIFT:
  - Each transfer shifts shadow right, inserting key_bit at shadow[KEY_WIDTH-1], and increments count.
  - After KEY_WIDTH transfers, shadow[i] = i-th bit received (0-based).
  - Transfer with count==KEY_WIDTH-1 leads to DONE, or to CHECK when the feature is enabled.
- Commit:
  - On entry to DONE, locking_key<=shadow and key_valid<=1, visible the cycle after the final accepted bit.
  - Latency is exactly 1 cycle; no combinational path from key_bit to locking_key.
- DONE: hold locking_key and key_valid until key_start or rst.
- Partial keys are never visible on locking_key; it is either 0 or a complete committed key.
- No backpressure stall: bubbles (key_bit_valid low) simply pause count.

Optional Feature:
- Macro: KEY_LOADER_CRC_EN.
- Enabled:
  - A CRC-8 (poly 0x07, init 0x00) is updated serially on every SHIFT transfer: crc <= {crc[6:0],0} ^ ((crc[7]^key_bit) ? 8'h07 : 8'h00).
  - After the key bits, state CHECK accepts 8 more bits, MSB first, into rx_crc.
  - On the 8th CHECK transfer: if rx_crc==crc, go to DONE with commit as above.
  - Otherwise go to ERROR: key_error=1, key_valid=0, locking_key stays 0.
  - ERROR exits only via key_start (clears key_error) or rst.
  - CRC and rx_crc are cleared on key_start and rst.
- Disabled: no CHECK/ERROR states, no CRC logic; key_error tied 0; SHIFT goes directly to DONE.

Test Plan:
- Reset: hold rst 2 cycles, then release -> locking_key=0, key_valid=0, key_busy=0, key_bit_ready=0; key_bit_valid=1 while IDLE -> no state change.
- Continuous load: key_start, then 255 bits with bits 0 and 8 =1, rest 0, key_bit_valid high every cycle -> key_bit_ready high 255 cycles; one cycle after last transfer key_valid=1, locking_key=255'h101, key_busy=0.
- Bubbles: same key, key_bit_valid toggling 1/0 -> completion after 509 cycles of streaming; identical locking_key=255'h101; count never advances on bubble cycles.
- Abort/restart: key_start, 100 bits of 1, key_start again (a bit offered in the same cycle), then 255 bits with only bit 0 =1 -> locking_key=255'h1; earlier bits and the collided bit are absent.
- Reset mid-load: after 50 accepted bits assert rst -> all outputs 0, state IDLE; subsequent bits ignored until key_start.
- KEY_LOADER_CRC_EN: load 255'h101 followed by its correct CRC-8 -> key_valid=1; repeat with CRC bit 0 flipped -> key_error=1, key_valid=0, locking_key=0; then key_start -> key_error=0.
